seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller that shares one BCD-to-7-segment decoder among NUM_DIGITS common-anode digits.
- Holds a frame of BCD digits and presents one digit at a time on bcd_out, which feeds the decoder.
- Drives the active-low digit enables, with a blanking guard interval between digits to suppress ghosting.
- Sits between the counter/datapath logic that produces BCD values and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- REFRESH_DIV, 50000, clk cycles each digit is driven (DRIVE length, >=1).
- GUARD, 8, clk cycles all digits are off before each digit (BLANK length, >=1).
- CNT_W, 16, width of the phase counter; must hold max(REFRESH_DIV, GUARD)-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  scan enable; low forces idle with the display dark.
- load  in  1  one-cycle strobe that captures digits_in.
- digits_in  in  4*NUM_DIGITS  BCD frame; digit k at bits [4k+3:4k]; digit 0 is the rightmost digit.
- bcd_out  out  4  BCD code to the decoder, MSB-first: bit3 drives decoder input I0, bit0 drives I3.
- an_out  out  NUM_DIGITS  digit enables, active-low, one-cold or all-high.
- frame_done  out  1  one-cycle pulse at the end of each full scan.

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low (rst_n).
- Reset values:
  - an_out = all 1.
  - bcd_out = 4'b0000.
  - frame_done = 0.
  - digit index = 0, phase counter = 0, state = IDLE.
  - active frame = 0, pending frame = 0, pending flag = 0.
- States:
  - IDLE: all digits off. Go to BLANK when enable=1.
  - BLANK: an_out all 1 for GUARD cycles. bcd_out is loaded with active[idx] on entry and held stable, so the decoder settles before its digit turns on. Then go to DRIVE.
  - DRIVE: an_out[idx] = 0 for REFRESH_DIV cycles, other bits 1. On exit, idx = idx+1, wrapping NUM_DIGITS-1 -> 0, then go to BLANK.
- Registered outputs: an_out changes on the clock edge that enters the state. Latency from enable rising to the first digit lit is GUARD+1 cycles.
- Invalid code: if active[idx] > 9, the decoder output is undefined. an_out stays all 1 for that digit's whole DRIVE slot. Timing is unchanged.
- Frame boundary: the last cycle of DRIVE for idx = NUM_DIGITS-1.
  - frame_done = 1 in the cycle after the boundary.
  - If pending flag = 1, active <= pending and the flag is cleared at the boundary.
- load handling:
  - load=1 captures digits_in into pending and sets the flag.
  - The active frame never changes mid-frame, so there is no tearing.
  - Repeated loads before the boundary overwrite pending; the last one wins.
  - load on the boundary cycle writes digits_in directly into active; pending is unchanged and the flag is cleared.
  - load during IDLE goes directly to active.
- enable deassert, any state: next cycle is IDLE, with an_out all 1, idx = 0, counter = 0, frame_done = 0. The active and pending frames are retained.
- rst_n assertion mid-operation: all registers return to their reset values immediately (asynchronously).

Optional Feature:
- Macro: SEG7_SCAN_LZ_SUPPRESS_EN (leading-zero suppression).
- Defined:
  - Digit k > 0 is blanked (an_out bit held 1 in its DRIVE slot) when it and every digit above it is 0.
  - Digit 0 is always shown.
  - Evaluated on the active frame.
- Undefined: all digits are shown, including leading zeros. No extra logic is generated.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, GUARD=1):
- Reset, enable=1, load 16'h1234 in IDLE -> sequence 1110(bcd 4), 1101(3), 1011(2), 0111(1), each low 4 cycles with 1 cycle of 1111 between; frame_done pulses every 20 cycles.
- Load 16'h5678 in the middle of digit 1 -> the rest of the frame still shows 1234; the next frame shows 8,7,6,5.
- Two loads 16'h1111 then 16'h2222 in the same frame -> the next frame shows all 2s. Load 16'h9999 exactly on the boundary cycle -> it appears in the immediately following frame.
- Frame 16'h12A4 -> digit 1 slot has an_out=1111 for its 4 cycles; all other digits are normal and frame timing is unchanged.
- enable drops during DRIVE of digit 2 -> next cycle an_out=1111, state IDLE. Re-enable -> digit 0 lights after 2 cycles. rst_n pulse mid-DRIVE -> outputs reset without waiting for a clock edge.
- With SEG7_SCAN_LZ_SUPPRESS_EN, frame 16'h0070 -> digits 3 and 2 dark, digit 1 shows 7, digit 0 shows 0. Frame 16'h0000 -> only digit 0 is lit.

Source files
------------

// File: rtl/seg7_scan_ctrl_if.sv
// Bundle between BCD frame producer and the 7-segment scan controller.
// master: frame producer / display consumer side; slave: seg7_scan_ctrl.
interface seg7_scan_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                    enable;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [3:0]              bcd_out;
  logic [NUM_DIGITS-1:0]   an_out;
  logic                    frame_done;

  modport master (
    output enable,
    output load,
    output digits_in,
    input  bcd_out,
    input  an_out,
    input  frame_done
  );

  modport slave (
    input  enable,
    input  load,
    input  digits_in,
    output bcd_out,
    output an_out,
    output frame_done
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits sharing one decoder.
// Optional leading-zero suppression: define SEG7_SCAN_LZ_SUPPRESS_EN.
module seg7_scan_ctrl #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned GUARD       = 8,
  parameter int unsigned CNT_W       = 16
) (
  input logic             clk,
  input logic             rst_n,
  seg7_scan_ctrl_if.slave bus
);

  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] DriveLast = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GuardLast = CNT_W'(GUARD - 1);
  localparam logic [IdxW-1:0]  IdxLast   = IdxW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StBlank, StDrive} state_e;

  state_e                  st_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [IdxW-1:0]         idx_q;
  logic [IdxW-1:0]         idx_inc;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
  logic                    pend_vld_q, pend_vld_d;
  logic [3:0]              bcd_q;
  logic [NUM_DIGITS-1:0]   an_q;
  logic                    frame_done_q;
  logic                    boundary;
  logic                    lz_hide;
  logic                    show;

  function automatic logic [3:0] digit_of(input logic [4*NUM_DIGITS-1:0] f,
                                          input logic [IdxW-1:0] i);
    logic [3:0] d;
    d = 4'h0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (i == IdxW'(k)) d = f[4*k +: 4];
    end
    return d;
  endfunction

  assign boundary = (st_q == StDrive) && (cnt_q == DriveLast) && (idx_q == IdxLast) &&
                    bus.enable;
  assign idx_inc  = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);

  // Active frame only changes while idle or at the frame boundary, so a frame never tears.
  always_comb begin
    active_d   = active_q;
    pending_d  = pending_q;
    pend_vld_d = pend_vld_q;
    if (bus.load) begin
      if (st_q == StIdle || boundary) begin
        active_d   = bus.digits_in;
        pend_vld_d = 1'b0;
      end else begin
        pending_d  = bus.digits_in;
        pend_vld_d = 1'b1;
      end
    end else if (boundary && pend_vld_q) begin
      active_d   = pending_q;
      pend_vld_d = 1'b0;
    end
  end

`ifdef SEG7_SCAN_LZ_SUPPRESS_EN
  // lz_zero[k]: digit k and every digit above it are zero.
  logic [NUM_DIGITS-1:0] lz_zero;
  always_comb begin
    lz_zero = '0;
    lz_zero[NUM_DIGITS-1] = (active_q[4*NUM_DIGITS-1 -: 4] == 4'h0);
    for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
      lz_zero[k] = lz_zero[k+1] && (active_q[4*k +: 4] == 4'h0);
    end
  end
  assign lz_hide = (idx_q != '0) && lz_zero[idx_q];
`else
  assign lz_hide = 1'b0;
`endif

  // bcd_q already holds active[idx] here, having settled during BLANK.
  assign show = (bcd_q <= 4'd9) && !lz_hide;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q         <= StIdle;
      cnt_q        <= '0;
      idx_q        <= '0;
      active_q     <= '0;
      pending_q    <= '0;
      pend_vld_q   <= 1'b0;
      bcd_q        <= 4'h0;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      active_q     <= active_d;
      pending_q    <= pending_d;
      pend_vld_q   <= pend_vld_d;
      frame_done_q <= 1'b0;
      if (!bus.enable) begin
        st_q  <= StIdle;
        cnt_q <= '0;
        idx_q <= '0;
        an_q  <= '1;
      end else begin
        unique case (st_q)
          StIdle: begin
            st_q  <= StBlank;
            cnt_q <= '0;
            idx_q <= '0;
            bcd_q <= digit_of(active_d, '0);
            an_q  <= '1;
          end
          StBlank: begin
            if (cnt_q == GuardLast) begin
              st_q  <= StDrive;
              cnt_q <= '0;
              an_q  <= show ? ~(NUM_DIGITS'(1) << idx_q) : '1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          StDrive: begin
            if (cnt_q == DriveLast) begin
              st_q         <= StBlank;
              cnt_q        <= '0;
              idx_q        <= idx_inc;
              bcd_q        <= digit_of(active_d, idx_inc);
              an_q         <= '1;
              frame_done_q <= boundary;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            st_q  <= StIdle;
            cnt_q <= '0;
            idx_q <= '0;
            an_q  <= '1;
          end
        endcase
      end
    end
  end

  assign bus.bcd_out    = bcd_q;
  assign bus.an_out     = an_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized and directed bench for seg7_scan_ctrl against a frame-position reference model.
module tb_seg7_scan_ctrl;

  localparam int unsigned N = 4;
  localparam int unsigned R = 4;
  localparam int unsigned G = 1;
  localparam int unsigned S = G + R;
  localparam int unsigned L = N * S;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

  seg7_scan_ctrl #(
    .NUM_DIGITS (N),
    .REFRESH_DIV(R),
    .GUARD      (G),
    .CNT_W      (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: scan position within the frame rather than any state machine.
  bit          running;
  int          pos;
  logic [15:0] m_active, m_pending;
  bit          m_flag;
  logic [3:0]  exp_an;
  logic        exp_fd;
  logic [3:0]  exp_bcd;
  bit          bcd_known;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [3:0] nib(input logic [15:0] f, input int k);
    logic [15:0] t;
    t = f >> (4 * k);
    return t[3:0];
  endfunction

  function automatic bit lz_hidden(input logic [15:0] f, input int k);
`ifdef SEG7_SCAN_LZ_SUPPRESS_EN
    return (k > 0) && ((f >> (4 * k)) == 16'h0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    running   = 0;
    pos       = 0;
    m_active  = '0;
    m_pending = '0;
    m_flag    = 0;
    exp_an    = 4'hf;
    exp_fd    = 1'b0;
    exp_bcd   = 4'h0;
    bcd_known = 1;
  endtask

  task automatic model_step(input bit en, input bit ld, input logic [15:0] din);
    bit bnd;
    int slot;
    if (!running) begin
      if (ld) begin
        m_active = din;
        m_flag   = 0;
      end
      if (en) begin
        running = 1;
        pos     = 0;
      end
      exp_fd = 1'b0;
    end else if (!en) begin
      if (ld) begin
        m_pending = din;
        m_flag    = 1;
      end
      running   = 0;
      exp_fd    = 1'b0;
      bcd_known = 0;
    end else begin
      bnd = (pos == L - 1);
      if (ld) begin
        if (bnd) begin
          m_active = din;
          m_flag   = 0;
        end else begin
          m_pending = din;
          m_flag    = 1;
        end
      end else if (bnd && m_flag) begin
        m_active = m_pending;
        m_flag   = 0;
      end
      pos    = (pos + 1) % L;
      exp_fd = bnd;
    end
    exp_an = 4'hf;
    if (running) begin
      slot      = pos / S;
      exp_bcd   = nib(m_active, slot);
      bcd_known = 1;
      if ((pos % S) >= G && exp_bcd <= 4'd9 && !lz_hidden(m_active, slot))
        exp_an = ~(4'b0001 << slot);
    end
  endtask

  task automatic cycle(input bit en, input bit ld, input logic [15:0] din);
    bus.enable    = en;
    bus.load      = ld;
    bus.digits_in = din;
    @(posedge clk);
    model_step(en, ld, din);
    #1;
    check("an_out", 32'(bus.an_out), 32'(exp_an));
    check("frame_done", 32'(bus.frame_done), 32'(exp_fd));
    if (bcd_known) check("bcd_out", 32'(bus.bcd_out), 32'(exp_bcd));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 16'($urandom));
  endtask

  // Advance until the model sits at position tgt, so the next cycle's inputs land there.
  task automatic run_to(input int tgt);
    for (int i = 0; i < 2 * L && pos != tgt; i++) cycle(1'b1, 1'b0, 16'($urandom));
    check("run_to", 32'(pos), 32'(tgt));
  endtask

  function automatic logic [15:0] rand_frame();
    logic [15:0] f;
    int r;
    f = '0;
    for (int k = 0; k < 4; k++) begin
      r = $urandom_range(0, 15);
      if (r > 9 && $urandom_range(0, 3) != 0) r = 0;
      f = f | (16'(r) << (4 * k));
    end
    return f;
  endfunction

  initial begin
    bus.enable    = 1'b0;
    bus.load      = 1'b0;
    bus.digits_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset an_out", 32'(bus.an_out), 32'hf);
    check("reset bcd_out", 32'(bus.bcd_out), 32'h0);
    check("reset frame_done", 32'(bus.frame_done), 32'h0);
    rst_n = 1'b1;

    // Idle cycles, then load in IDLE together with enable.
    cycle(1'b0, 1'b0, 16'h0);
    cycle(1'b1, 1'b1, 16'h1234);
    run(2 * L);

    // Load mid digit 1: current frame keeps 1234.
    run_to(7);
    cycle(1'b1, 1'b1, 16'h5678);
    run(2 * L);

    // Two loads in one frame, last wins; then a load on the boundary cycle.
    run_to(3);
    cycle(1'b1, 1'b1, 16'h1111);
    run_to(12);
    cycle(1'b1, 1'b1, 16'h2222);
    run(L);
    run_to(L - 1);
    cycle(1'b1, 1'b1, 16'h9999);
    run(L);

    // Invalid code in digit 1.
    run_to(L - 1);
    cycle(1'b1, 1'b1, 16'h12A4);
    run(2 * L);

    // Leading-zero frames.
    run_to(L - 1);
    cycle(1'b1, 1'b1, 16'h0070);
    run(L + 1);
    run_to(L - 1);
    cycle(1'b1, 1'b1, 16'h0000);
    run(L + 1);

    // Enable drop during DRIVE of digit 2, then re-enable.
    run_to(L - 1);
    cycle(1'b1, 1'b1, 16'h4321);
    run_to(12);
    cycle(1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 16'h0);
    run(L + 3);

    // Asynchronous reset mid-DRIVE of digit 1 (bcd 2, digit lit).
    run_to(7);
    #2;
    rst_n = 1'b0;
    #1;
    check("async an_out", 32'(bus.an_out), 32'hf);
    check("async bcd_out", 32'(bus.bcd_out), 32'h0);
    check("async frame_done", 32'(bus.frame_done), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b1, 1'b1, 16'h8765);
    run(L);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) < 96), ($urandom_range(0, 9) == 0), rand_frame());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
